// File: rtl/analyser_pkg.sv
// Shared defaults for the buffered signal analyser.
// Holds width/depth defaults and the saturating drop-counter helper.
package analyser_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TIME_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;
  localparam int DROP_WIDTH     = 16;

  function automatic logic [DROP_WIDTH-1:0] sat_inc(
    input logic [DROP_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/analyser_fifo.sv
// Synchronous show-ahead FIFO: dout is the head entry whenever !empty.
// Ports: clk, rst, push/din, pop, dout, full, empty, count.
module analyser_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             wr_en;
  logic             rd_en;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is legal only when the head leaves
  // on the same edge.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/buffered_signal_analyser.sv
// Timestamps masked changes on dataIn and buffers them for a consumer.
// Ports: clk, rst, dataIn, mask, enable in; outReady/outValid handshake,
// dataOut/dataTime head entry, count, overflow, dropped status out.
module buffered_signal_analyser
  import analyser_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIME_WIDTH = DEF_TIME_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  dataIn,
  input  logic [DATA_WIDTH-1:0]  mask,
  input  logic                   enable,
  input  logic                   outReady,
  output logic                   outValid,
  output logic [DATA_WIDTH-1:0]  dataOut,
  output logic [TIME_WIDTH-1:0]  dataTime,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_WIDTH-1:0]  dropped
);

  localparam int EW = DATA_WIDTH + TIME_WIDTH;

  logic [TIME_WIDTH-1:0] tnow;
  logic [DATA_WIDTH-1:0] last_data;
  logic                  primer;
  logic [EW-1:0]         hold_q;
  logic [EW-1:0]         head;
  logic [EW-1:0]         shown;
  logic                  full;
  logic                  empty;
  logic                  evt;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // Primer forces the first enabled sample through regardless of mask.
  assign evt  = enable &&
                (primer || |((dataIn ^ last_data) & mask));
  assign pop  = !empty && outReady;
  assign push = evt && (!full || pop);
  assign drop = evt && full && !pop;

  analyser_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({dataIn, tnow}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // While empty the FIFO head is stale, so show the last head seen.
  assign outValid = !empty;
  assign shown    = empty ? hold_q : head;
  assign dataOut  = shown[EW-1:TIME_WIDTH];
  assign dataTime = shown[TIME_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      tnow      <= '0;
      last_data <= '0;
      primer    <= 1'b1;
      hold_q    <= '0;
      overflow  <= 1'b0;
      dropped   <= '0;
    end else begin
      tnow   <= tnow + 1'b1;
      primer <= !enable;
      if (enable) last_data <= dataIn;
      if (!empty) hold_q <= head;
      if (drop) begin
        overflow <= 1'b1;
        dropped  <= sat_inc(dropped);
      end
    end
  end

endmodule

// File: tb/tb_buffered_signal_analyser.sv
// Directed bench for buffered_signal_analyser.
// Vector table for basic behaviour, hand sequences for overflow/wrap/reset.
module tb_buffered_signal_analyser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dataIn;
  logic [7:0] mask;
  logic       enable;
  logic       outReady;

  logic        outValid;
  logic [7:0]  dataOut;
  logic [31:0] dataTime;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] dropped;

  logic        valid4;
  logic [7:0]  dout4;
  logic [3:0]  time4;
  logic [4:0]  count4;
  logic        ovf4;
  logic [15:0] drop4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  buffered_signal_analyser u_dut (
    .clk      (clk),
    .rst      (rst),
    .dataIn   (dataIn),
    .mask     (mask),
    .enable   (enable),
    .outReady (outReady),
    .outValid (outValid),
    .dataOut  (dataOut),
    .dataTime (dataTime),
    .count    (count),
    .overflow (overflow),
    .dropped  (dropped)
  );

  buffered_signal_analyser #(
    .TIME_WIDTH (4)
  ) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .dataIn   (dataIn),
    .mask     (mask),
    .enable   (enable),
    .outReady (outReady),
    .outValid (valid4),
    .dataOut  (dout4),
    .dataTime (time4),
    .count    (count4),
    .overflow (ovf4),
    .dropped  (drop4)
  );

  typedef struct {
    logic [7:0]  din;
    logic [7:0]  msk;
    logic        en;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic [31:0] et;
    logic [4:0]  ec;
  } vec_t;

  vec_t tv[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    tick();
    rst    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    dataIn   = 8'h00;
    mask     = 8'hFF;
    enable   = 1'b0;
    outReady = 1'b0;

    // din msk en rdy | valid data time count
    tv[0]  = '{8'd69,  8'hFF, 1'b1, 1'b0, 1'b1, 8'd69,  32'd0,  5'd1};
    tv[1]  = '{8'd69,  8'hFF, 1'b1, 1'b0, 1'b1, 8'd69,  32'd0,  5'd1};
    tv[2]  = '{8'd69,  8'hFF, 1'b1, 1'b1, 1'b0, 8'd69,  32'd0,  5'd0};
    tv[3]  = '{8'd100, 8'hFF, 1'b1, 1'b0, 1'b1, 8'd100, 32'd3,  5'd1};
    tv[4]  = '{8'd100, 8'hFF, 1'b1, 1'b1, 1'b0, 8'd100, 32'd3,  5'd0};
    tv[5]  = '{8'd100, 8'hFF, 1'b1, 1'b1, 1'b0, 8'd100, 32'd3,  5'd0};
    tv[6]  = '{8'h00,  8'hFF, 1'b1, 1'b0, 1'b1, 8'h00,  32'd6,  5'd1};
    tv[7]  = '{8'h00,  8'h0F, 1'b1, 1'b1, 1'b0, 8'h00,  32'd6,  5'd0};
    tv[8]  = '{8'hF0,  8'h0F, 1'b1, 1'b0, 1'b0, 8'h00,  32'd6,  5'd0};
    tv[9]  = '{8'hF1,  8'h0F, 1'b1, 1'b0, 1'b1, 8'hF1,  32'd9,  5'd1};
    tv[10] = '{8'hF1,  8'h0F, 1'b1, 1'b1, 1'b0, 8'hF1,  32'd9,  5'd0};
    tv[11] = '{8'h55,  8'hFF, 1'b0, 1'b1, 1'b0, 8'hF1,  32'd9,  5'd0};
    tv[12] = '{8'hF1,  8'h00, 1'b1, 1'b0, 1'b1, 8'hF1,  32'd12, 5'd1};
    tv[13] = '{8'hF1,  8'h00, 1'b1, 1'b1, 1'b0, 8'hF1,  32'd12, 5'd0};
    tv[14] = '{8'h0F,  8'h00, 1'b1, 1'b0, 1'b0, 8'hF1,  32'd12, 5'd0};
    tv[15] = '{8'h0E,  8'h01, 1'b1, 1'b0, 1'b1, 8'h0E,  32'd15, 5'd1};

    tick();
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_data",  32'(dataOut),  32'd0);
    chk("rst_time",  dataTime,      32'd0);
    chk("rst_count", 32'(count),    32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_drop",  32'(dropped),  32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      dataIn   = tv[i].din;
      mask     = tv[i].msk;
      enable   = tv[i].en;
      outReady = tv[i].rdy;
      tick();
      chk($sformatf("v%0d_valid", i), 32'(outValid), 32'(tv[i].ev));
      chk($sformatf("v%0d_data", i),  32'(dataOut),  32'(tv[i].ed));
      chk($sformatf("v%0d_time", i),  dataTime,      tv[i].et);
      chk($sformatf("v%0d_count", i), 32'(count),    32'(tv[i].ec));
    end
    chk("tbl_ovf",  32'(overflow), 32'd0);
    chk("tbl_drop", 32'(dropped),  32'd0);

    // Overflow: 20 changes with no consumer.
    do_reset();
    mask     = 8'hFF;
    enable   = 1'b1;
    outReady = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dataIn = 8'(i + 1);
      tick();
    end
    chk("ovf_count", 32'(count),    32'd16);
    chk("ovf_flag",  32'(overflow), 32'd1);
    chk("ovf_drop",  32'(dropped),  32'd4);
    chk("ovf_head_d", 32'(dataOut), 32'd1);
    chk("ovf_head_t", dataTime,     32'd0);

    // Full buffer: change with pop on the same edge is accepted.
    dataIn   = 8'hAA;
    outReady = 1'b1;
    tick();
    chk("fullpop_count", 32'(count),   32'd16);
    chk("fullpop_drop",  32'(dropped), 32'd4);

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_valid", i), 32'(outValid), 32'd1);
      chk($sformatf("drain%0d_data", i), 32'(dataOut),
          (i == 15) ? 32'hAA : 32'(i + 2));
      chk($sformatf("drain%0d_time", i), dataTime,
          (i == 15) ? 32'd20 : 32'(i + 1));
      tick();
    end
    chk("drain_valid", 32'(outValid), 32'd0);
    chk("drain_count", 32'(count),    32'd0);
    chk("drain_hold",  32'(dataOut),  32'hAA);
    chk("drain_htime", dataTime,      32'd20);
    chk("drain_ovf",   32'(overflow), 32'd1);
    chk("drain_drop",  32'(dropped),  32'd4);

    // Narrow timestamp wrap, then reset with entries buffered.
    do_reset();
    dataIn   = 8'h00;
    mask     = 8'hFF;
    enable   = 1'b1;
    outReady = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    chk("wrap_empty", 32'(valid4), 32'd0);
    dataIn   = 8'h33;
    outReady = 1'b0;
    tick();
    chk("wrap_valid", 32'(valid4), 32'd1);
    chk("wrap_data",  32'(dout4),  32'h33);
    chk("wrap_time",  32'(time4),  32'd1);
    chk("wide_time",  dataTime,    32'd17);
    dataIn = 8'h34;
    tick();
    dataIn = 8'h35;
    tick();
    chk("pre_rst_count", 32'(count4), 32'd3);

    rst    = 1'b1;
    dataIn = 8'h36;
    tick();
    chk("mid_rst_count", 32'(count4), 32'd0);
    chk("mid_rst_valid", 32'(valid4), 32'd0);
    chk("mid_rst_data",  32'(dout4),  32'd0);
    chk("mid_rst_time",  32'(time4),  32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(valid4), 32'd1);
    chk("post_rst_data",  32'(dout4),  32'h36);
    chk("post_rst_time",  32'(time4),  32'd0);
    chk("post_rst_count", 32'(count4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
